// File: rtl/lock_ctrl.sv
// Code-lock password controller: collects 4-digit entries from the debounced keypad,
// verifies them against a stored code, and handles unlock, lockout and code change.
module lock_ctrl #(
  parameter logic [15:0] DEFAULT_CODE  = 16'h1234,
  parameter int unsigned UNLOCK_TIME   = 5000,
  parameter int unsigned ENTRY_TIMEOUT = 10000,
  parameter int unsigned MAX_FAIL      = 3,
  parameter int unsigned LOCKOUT_TIME  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_value,
  input  logic        key_sured,
  output logic        unlock,
  output logic        alarm,
  output logic        err_pulse,
  output logic        saved_pulse,
  output logic [2:0]  digit_cnt,
  output logic [15:0] entry_buf,
  output logic [1:0]  fail_cnt
);

  typedef enum logic [2:0] {S_LOCKED, S_CHECK, S_OPEN, S_NEW_PW, S_LOCKOUT} state_t;

  localparam logic [19:0] LP_UNLOCK_END  = 20'(UNLOCK_TIME - 1);
  localparam logic [19:0] LP_ENTRY_END   = 20'(ENTRY_TIMEOUT - 1);
  localparam logic [19:0] LP_LOCKOUT_END = 20'(LOCKOUT_TIME - 1);
  localparam logic [2:0]  LP_MAX_FAIL    = 3'(MAX_FAIL);

  state_t      r_state, w_state_nxt;
  logic        r_key_q;
  logic [19:0] r_timer;
  logic [15:0] r_entry, r_code;
  logic [2:0]  r_digit_cnt;
  logic [1:0]  r_fail_cnt;
  logic        r_saved;

  logic w_key_evt, w_is_digit, w_is_enter, w_is_clear, w_is_change;
  logic w_match, w_state_chg, w_evt_live, w_entry_tmo, w_full, w_last_fail;

  assign w_key_evt   = key_sured & ~r_key_q;
  assign w_is_digit  = (key_value < 4'd10);
  assign w_is_enter  = (key_value == 4'd10);
  assign w_is_clear  = (key_value == 4'd11);
  assign w_is_change = (key_value == 4'd12);
  assign w_full      = (r_digit_cnt == 3'd4);
  assign w_match     = (r_entry == r_code);
  assign w_last_fail = ((3'(r_fail_cnt) + 3'd1) == LP_MAX_FAIL);
  assign w_state_chg = (w_state_nxt != r_state);
  // Events only matter (and only restart the timer) in the key-accepting states.
  assign w_evt_live  = w_key_evt &&
                       (r_state == S_LOCKED || r_state == S_OPEN || r_state == S_NEW_PW);
  assign w_entry_tmo = (r_state == S_LOCKED) && (r_digit_cnt != 3'd0) &&
                       !w_key_evt && (r_timer == LP_ENTRY_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOCKED;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOCKED:  if (w_key_evt && w_is_enter && w_full) w_state_nxt = S_CHECK;
      S_CHECK:   if (w_match)          w_state_nxt = S_OPEN;
                 else if (w_last_fail) w_state_nxt = S_LOCKOUT;
                 else                  w_state_nxt = S_LOCKED;
      S_OPEN:    if (w_key_evt && w_is_enter)       w_state_nxt = S_LOCKED;
                 else if (w_key_evt && w_is_change) w_state_nxt = S_NEW_PW;
                 else if (!w_key_evt && r_timer == LP_UNLOCK_END) w_state_nxt = S_LOCKED;
      S_NEW_PW:  if (w_key_evt && w_is_enter && w_full) w_state_nxt = S_LOCKED;
                 else if (!w_key_evt && r_timer == LP_ENTRY_END) w_state_nxt = S_LOCKED;
      S_LOCKOUT: if (r_timer == LP_LOCKOUT_END) w_state_nxt = S_LOCKED;
      default:   w_state_nxt = S_LOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_q     <= 1'b0;
      r_timer     <= '0;
      r_entry     <= '0;
      r_digit_cnt <= '0;
      r_fail_cnt  <= '0;
      r_code      <= DEFAULT_CODE;
      r_saved     <= 1'b0;
    end else begin
      r_key_q <= key_sured;
      r_saved <= 1'b0;

      if (w_state_chg || w_evt_live || w_entry_tmo ||
          (r_state == S_LOCKED && r_digit_cnt == 3'd0))
        r_timer <= '0;
      else
        r_timer <= r_timer + 20'd1;

      // Entry survives only the LOCKED->CHECK hop; every other transition discards it.
      if (w_state_chg && w_state_nxt != S_CHECK) begin
        r_entry     <= '0;
        r_digit_cnt <= '0;
      end else if (w_evt_live && r_state != S_OPEN) begin
        if (w_is_digit && !w_full) begin
          r_entry     <= {r_entry[11:0], key_value};
          r_digit_cnt <= r_digit_cnt + 3'd1;
        end else if (w_is_clear) begin
          r_entry     <= '0;
          r_digit_cnt <= '0;
        end
      end else if (w_entry_tmo) begin
        r_entry     <= '0;
        r_digit_cnt <= '0;
      end

      if (r_state == S_CHECK)
        r_fail_cnt <= w_match ? 2'd0 : r_fail_cnt + 2'd1;
      else if (r_state == S_LOCKOUT && w_state_chg)
        r_fail_cnt <= '0;

      if (r_state == S_NEW_PW && w_key_evt && w_is_enter && w_full) begin
        r_code  <= r_entry;
        r_saved <= 1'b1;
      end
    end
  end

  always_comb begin
    unlock    = 1'b0;
    alarm     = 1'b0;
    err_pulse = 1'b0;
    case (r_state)
      S_OPEN, S_NEW_PW: unlock    = 1'b1;
      S_LOCKOUT:        alarm     = 1'b1;
      S_CHECK:          err_pulse = !w_match;
      default:          ;
    endcase
  end

  assign saved_pulse = r_saved;
  assign digit_cnt   = r_digit_cnt;
  assign entry_buf   = r_entry;
  assign fail_cnt    = r_fail_cnt;

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed self-checking bench for lock_ctrl with shortened timing parameters.
module tb_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_value = 4'd0;
  logic        key_sured = 1'b0;
  logic        unlock, alarm, err_pulse, saved_pulse;
  logic [2:0]  digit_cnt;
  logic [15:0] entry_buf;
  logic [1:0]  fail_cnt;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int saved_seen = 0;
  int cyc = 0;

  lock_ctrl #(
    .DEFAULT_CODE (16'h1234),
    .UNLOCK_TIME  (50),
    .ENTRY_TIMEOUT(300),
    .MAX_FAIL     (3),
    .LOCKOUT_TIME (120)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_value  (key_value),
    .key_sured  (key_sured),
    .unlock     (unlock),
    .alarm      (alarm),
    .err_pulse  (err_pulse),
    .saved_pulse(saved_pulse),
    .digit_cnt  (digit_cnt),
    .entry_buf  (entry_buf),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (err_pulse)   err_seen++;
    if (saved_pulse) saved_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1);
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_value = k;
    key_sured = 1'b1;
    repeat (10) @(negedge clk);
    key_sured = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] c);
    press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]);
    press(4'd10);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (unlock !== 1'b0)     begin errors++; $display("FAIL reset_unlock: got %b expected 0", unlock); end
    checks++; if (alarm !== 1'b0)      begin errors++; $display("FAIL reset_alarm: got %b expected 0", alarm); end
    checks++; if (digit_cnt !== 3'd0)  begin errors++; $display("FAIL reset_digit_cnt: got %0d expected 0", digit_cnt); end
    checks++; if (entry_buf !== 16'h0) begin errors++; $display("FAIL reset_entry_buf: got %h expected 0000", entry_buf); end
    checks++; if (fail_cnt !== 2'd0)   begin errors++; $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); end
    checks++; if ({err_pulse, saved_pulse} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {err_pulse, saved_pulse}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unlock;
    int t0;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    checks++; if (entry_buf !== 16'h1234) begin errors++; $display("FAIL unlock_entry: got %h expected 1234", entry_buf); end
    @(negedge clk);
    key_value = 4'd10;
    key_sured = 1'b1;
    @(negedge clk);
    checks++; if (unlock !== 1'b0) begin errors++; $display("FAIL unlock_latency1: got %b expected 0", unlock); end
    @(negedge clk);
    checks++; if (unlock !== 1'b1) begin errors++; $display("FAIL unlock_latency2: got %b expected 1", unlock); end
    checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL unlock_fail_cnt: got %0d expected 0", fail_cnt); end
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL unlock_digit_clr: got %0d expected 0", digit_cnt); end
    t0 = cyc;
    repeat (8) @(negedge clk);
    key_sured = 1'b0;
    while (unlock === 1'b1 && cyc - t0 < 500) @(negedge clk);
    checks++; if (cyc - t0 !== 50) begin errors++; $display("FAIL unlock_duration: got %0d expected 50", cyc - t0); end
  endtask

  task automatic test_fail_lockout;
    int e0, t0;
    e0 = err_seen;
    enter_code(16'h1235);
    checks++; if (err_seen - e0 !== 1) begin errors++; $display("FAIL fail1_err: got %0d expected 1", err_seen - e0); end
    checks++; if (fail_cnt !== 2'd1)   begin errors++; $display("FAIL fail1_cnt: got %0d expected 1", fail_cnt); end
    enter_code(16'h1235);
    checks++; if (err_seen - e0 !== 2) begin errors++; $display("FAIL fail2_err: got %0d expected 2", err_seen - e0); end
    checks++; if (fail_cnt !== 2'd2)   begin errors++; $display("FAIL fail2_cnt: got %0d expected 2", fail_cnt); end
    checks++; if (alarm !== 1'b0)      begin errors++; $display("FAIL fail2_alarm: got %b expected 0", alarm); end
    press(4'd1); press(4'd2); press(4'd3); press(4'd5);
    @(negedge clk);
    key_value = 4'd10;
    key_sured = 1'b1;
    @(negedge clk);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL fail3_err_pulse: got %b expected 1", err_pulse); end
    @(negedge clk);
    checks++; if (alarm !== 1'b1)    begin errors++; $display("FAIL lockout_alarm: got %b expected 1", alarm); end
    checks++; if (fail_cnt !== 2'd3) begin errors++; $display("FAIL lockout_fail_cnt: got %0d expected 3", fail_cnt); end
    t0 = cyc;
    key_sured = 1'b0;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd10);
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL lockout_keys_ignored: got %0d expected 0", digit_cnt); end
    checks++; if (unlock !== 1'b0)    begin errors++; $display("FAIL lockout_unlock: got %b expected 0", unlock); end
    while (alarm === 1'b1 && cyc - t0 < 1000) @(negedge clk);
    checks++; if (cyc - t0 !== 120)  begin errors++; $display("FAIL lockout_duration: got %0d expected 120", cyc - t0); end
    checks++; if (fail_cnt !== 2'd0) begin errors++; $display("FAIL lockout_exit_fail_cnt: got %0d expected 0", fail_cnt); end
    checks++; if (err_seen - e0 !== 3) begin errors++; $display("FAIL lockout_err_total: got %0d expected 3", err_seen - e0); end
    enter_code(16'h1234);
    checks++; if (unlock !== 1'b1) begin errors++; $display("FAIL post_lockout_unlock: got %b expected 1", unlock); end
    press(4'd10);
    checks++; if (unlock !== 1'b0) begin errors++; $display("FAIL enter_relocks: got %b expected 0", unlock); end
  endtask

  task automatic test_entry_edit;
    int e0;
    e0 = err_seen;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'd6);
    checks++; if (digit_cnt !== 3'd4)     begin errors++; $display("FAIL overflow_cnt: got %0d expected 4", digit_cnt); end
    checks++; if (entry_buf !== 16'h1234) begin errors++; $display("FAIL overflow_buf: got %h expected 1234", entry_buf); end
    press(4'd11);
    checks++; if ({digit_cnt, entry_buf} !== 19'd0) begin errors++; $display("FAIL clear: got %0d/%h expected 0/0000", digit_cnt, entry_buf); end
    press(4'd9); press(4'd10);
    checks++; if (digit_cnt !== 3'd1 || entry_buf !== 16'h0009) begin errors++; $display("FAIL short_enter: got %0d/%h expected 1/0009", digit_cnt, entry_buf); end
    checks++; if (err_seen - e0 !== 0 || unlock !== 1'b0) begin errors++; $display("FAIL short_enter_effect: got err %0d unlock %b expected 0 0", err_seen - e0, unlock); end
    press(4'd11);
  endtask

  task automatic test_change_code;
    int e0, s0;
    e0 = err_seen;
    s0 = saved_seen;
    enter_code(16'h1234);
    press(4'd12);
    checks++; if (unlock !== 1'b1 || digit_cnt !== 3'd0) begin errors++; $display("FAIL newpw_enter: got unlock %b cnt %0d expected 1 0", unlock, digit_cnt); end
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    checks++; if (entry_buf !== 16'h9876) begin errors++; $display("FAIL newpw_buf: got %h expected 9876", entry_buf); end
    press(4'd10);
    checks++; if (saved_seen - s0 !== 1) begin errors++; $display("FAIL saved_pulse: got %0d expected 1", saved_seen - s0); end
    checks++; if (unlock !== 1'b0)       begin errors++; $display("FAIL newpw_locked: got %b expected 0", unlock); end
    enter_code(16'h1234);
    checks++; if (err_seen - e0 !== 1 || unlock !== 1'b0) begin errors++; $display("FAIL old_code_rejected: got err %0d unlock %b expected 1 0", err_seen - e0, unlock); end
    enter_code(16'h9876);
    checks++; if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin errors++; $display("FAIL new_code_unlock: got unlock %b fail %0d expected 1 0", unlock, fail_cnt); end
    press(4'd10);
  endtask

  task automatic test_timeout;
    press(4'd1); press(4'd2);
    repeat (238) @(negedge clk);
    checks++; if (digit_cnt !== 3'd2) begin errors++; $display("FAIL timeout_early: got %0d expected 2", digit_cnt); end
    repeat (60) @(negedge clk);
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL timeout_clear: got %0d expected 0", digit_cnt); end
    @(negedge clk);
    key_value = 4'd5;
    key_sured = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (digit_cnt !== 3'd1 || entry_buf !== 16'h0005) begin errors++; $display("FAIL held_key: got %0d/%h expected 1/0005", digit_cnt, entry_buf); end
    key_sured = 1'b0;
    repeat (2) @(negedge clk);
    press(4'd11);
  endtask

  task automatic test_reset_newpw;
    enter_code(16'h9876);
    press(4'd12); press(4'd1); press(4'd2);
    checks++; if (digit_cnt !== 3'd2 || unlock !== 1'b1) begin errors++; $display("FAIL pre_rst_newpw: got cnt %0d unlock %b expected 2 1", digit_cnt, unlock); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({unlock, alarm, err_pulse, saved_pulse} !== 4'b0000) begin errors++; $display("FAIL rst_outputs: got %b expected 0000", {unlock, alarm, err_pulse, saved_pulse}); end
    checks++; if ({digit_cnt, entry_buf, fail_cnt} !== 21'd0) begin errors++; $display("FAIL rst_regs: got %0d/%h/%0d expected 0/0000/0", digit_cnt, entry_buf, fail_cnt); end
    @(negedge clk);
    rst = 1'b0;
    enter_code(16'h1234);
    checks++; if (unlock !== 1'b1) begin errors++; $display("FAIL rst_default_code: got %b expected 1", unlock); end
    press(4'd10);
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_fail_lockout();
    test_entry_edit();
    test_change_code();
    test_timeout();
    test_reset_newpw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
